// File: rtl/mult_div_unit.sv
// ---------------------------------------------------------------------------
// mult_div_unit
//
// Iterative multiply/divide unit with HI/LO result registers for the MIPS
// datapath. It executes MULT, MULTU, DIV and DIVU one bit per cycle over W
// cycles, then spends one extra cycle applying result signs. The result is
// written to HI/LO, and a one-cycle done pulse follows.
//
// Ports:
//   CLK       - clock, all state changes on the rising edge
//   reset     - synchronous, active-high reset
//   start     - operation request, only looked at while idle
//   op        - 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   rs_data   - multiplicand / dividend (register file read port 1)
//   rt_data   - multiplier / divisor (register file read port 2)
//   hi_we     - MTHI write enable (dropped while busy)
//   lo_we     - MTLO write enable (dropped while busy)
//   hi_wdata  - MTHI data
//   lo_wdata  - MTLO data
//   busy      - operation in progress (RUN or FIX)
//   done      - one-cycle pulse, HI/LO already hold the new result
//   hi, lo    - HI/LO registers
//
// Build option:
//   MDU_DIV_EN - when defined, the divider datapath is built. When it is
//                undefined, divide ops still take the full latency and
//                pulse done, but they leave HI/LO untouched.
// ---------------------------------------------------------------------------
module mult_div_unit #(
  parameter int W = 32
) (
  input  logic         CLK,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [W-1:0] rs_data,
  input  logic [W-1:0] rt_data,
  input  logic         hi_we,
  input  logic         lo_we,
  input  logic [W-1:0] hi_wdata,
  input  logic [W-1:0] lo_wdata,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo
);

  localparam int CW = $clog2(W) + 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(W - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t         r_state;
  state_t         w_nextState;
  logic [CW-1:0]  r_cnt;
  logic           r_isDiv;
  logic           r_negRes;
  logic [W-1:0]   r_opnd;
  logic [2*W-1:0] r_acc;
  logic [W-1:0]   r_hi;
  logic [W-1:0]   r_lo;
  logic           r_done;

  logic           w_accept;
  logic           w_rsNeg;
  logic           w_rtNeg;
  logic [W-1:0]   w_rsMag;
  logic [W-1:0]   w_rtMag;
  logic [W:0]     w_mulSum;
  logic [2*W-1:0] w_mulNext;
  logic [2*W-1:0] w_accNext;
  logic [2*W-1:0] w_prod;

`ifdef MDU_DIV_EN
  logic           r_negRem;
  logic           r_divZero;
  logic [W-1:0]   r_rs;
  logic [W:0]     w_divUpper;
  logic [W-1:0]   w_divDiff;
  logic [2*W-1:0] w_divNext;
  logic [W-1:0]   w_quot;
  logic [W-1:0]   w_rem;
`endif

  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

  // Ops with op[0] clear are signed. Their operands go through the unit as
  // magnitudes, and the signs are put back in FIX.
  assign w_rsNeg = ~op[0] & rs_data[W-1];
  assign w_rtNeg = ~op[0] & rt_data[W-1];
  assign w_rsMag = w_rsNeg ? -rs_data : rs_data;
  assign w_rtMag = w_rtNeg ? -rt_data : rt_data;

  // Shift-add multiply. The multiplier sits in the low half of the
  // accumulator and is consumed LSB first, while partial sums enter at the top.
  assign w_mulSum  = {1'b0, r_acc[2*W-1:W]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
  assign w_mulNext = {w_mulSum, r_acc[W-1:1]};

`ifdef MDU_DIV_EN
  // Restoring divide step. The upper half carries the partial remainder.
  // Quotient bits shift into the bottom as dividend bits leave the top.
  assign w_divUpper = r_acc[2*W-1:W-1];
  assign w_divDiff  = w_divUpper[W-1:0] - r_opnd;
  assign w_divNext  = (w_divUpper >= {1'b0, r_opnd})
                      ? {w_divDiff, r_acc[W-2:0], 1'b1}
                      : {w_divUpper[W-1:0], r_acc[W-2:0], 1'b0};
  assign w_quot     = r_negRes ? -r_acc[W-1:0] : r_acc[W-1:0];
  assign w_rem      = r_negRem ? -r_acc[2*W-1:W] : r_acc[2*W-1:W];
`endif

  assign w_prod = r_negRes ? -r_acc : r_acc;

  // Per-iteration accumulator update. In the multiply-only build, a divide
  // op just holds the accumulator while it runs out its latency.
  always_comb begin
    w_accNext = w_mulNext;
`ifdef MDU_DIV_EN
    if (r_isDiv) w_accNext = w_divNext;
`else
    if (r_isDiv) w_accNext = r_acc;
`endif
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  // Next-state logic. Busy covers both RUN and FIX.
  always_comb begin
    w_nextState = r_state;
    busy        = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_nextState = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (r_cnt == LAST_ITER) w_nextState = FIX;
      end
      FIX: begin
        busy        = 1'b1;
        w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Datapath. MTHI/MTLO writes and operand latching happen only in IDLE.
  // A write that lands together with an accepted start is later overwritten
  // by the result written in FIX.
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_cnt     <= '0;
      r_isDiv   <= 1'b0;
      r_negRes  <= 1'b0;
      r_opnd    <= '0;
      r_acc     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_done    <= 1'b0;
`ifdef MDU_DIV_EN
      r_negRem  <= 1'b0;
      r_divZero <= 1'b0;
      r_rs      <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (hi_we) r_hi <= hi_wdata;
          if (lo_we) r_lo <= lo_wdata;
          if (w_accept) begin
            r_cnt     <= '0;
            r_isDiv   <= op[1];
            r_negRes  <= w_rsNeg ^ w_rtNeg;
            r_opnd    <= op[1] ? w_rtMag : w_rsMag;
            r_acc     <= {{W{1'b0}}, (op[1] ? w_rsMag : w_rtMag)};
`ifdef MDU_DIV_EN
            r_negRem  <= w_rsNeg;
            r_divZero <= (rt_data == '0);
            r_rs      <= rs_data;
`endif
          end
        end
        RUN: begin
          r_acc <= w_accNext;
          r_cnt <= r_cnt + CW'(1);
        end
        FIX: begin
          r_done <= 1'b1;
          if (!r_isDiv) begin
            r_hi <= w_prod[2*W-1:W];
            r_lo <= w_prod[W-1:0];
          end
`ifdef MDU_DIV_EN
          else if (r_divZero) begin
            r_hi <= r_rs;
            r_lo <= '1;
          end else begin
            r_hi <= w_rem;
            r_lo <= w_quot;
          end
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// ---------------------------------------------------------------------------
// tb_mult_div_unit
//
// Self-checking bench for mult_div_unit. The driver issues operations and
// pushes each expected HI/LO pair into a queue. The expected values come
// from plain integer arithmetic. The monitor pops an entry whenever done
// pulses, and compares the result and the busy length.
// ---------------------------------------------------------------------------
module tb_mult_div_unit;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } exp_t;

  logic         CLK;
  logic         reset;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] rs_data;
  logic [W-1:0] rt_data;
  logic         hi_we;
  logic         lo_we;
  logic [W-1:0] hi_wdata;
  logic [W-1:0] lo_wdata;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  exp_t         expQ[$];
  logic [W-1:0] mHi;
  logic [W-1:0] mLo;
  int           checks;
  int           failures;
  int           busyRun;

  mult_div_unit #(.W(W)) dut (
    .CLK(CLK), .reset(reset), .start(start), .op(op),
    .rs_data(rs_data), .rt_data(rt_data),
    .hi_we(hi_we), .lo_we(lo_we), .hi_wdata(hi_wdata), .lo_wdata(lo_wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  // Free-running clock.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Compare one value and update the counters.
  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, expv);
    end
  endtask

  // Reference result computed from the architectural definition of each op.
  function automatic exp_t refModel(input logic [1:0] o, input logic [W-1:0] a,
                                    input logic [W-1:0] b, input logic [W-1:0] curHi,
                                    input logic [W-1:0] curLo);
    exp_t   r;
    longint sp;
    logic [63:0] up;
    int     sa, sb;
    r.hi = curHi;
    r.lo = curLo;
    case (o)
      2'b00: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        up = sp;
        r.hi = up[63:32];
        r.lo = up[31:0];
      end
      2'b01: begin
        up = {32'b0, a} * {32'b0, b};
        r.hi = up[63:32];
        r.lo = up[31:0];
      end
      default: begin
`ifdef MDU_DIV_EN
        if (b == 0) begin
          r.hi = a;
          r.lo = '1;
        end else if (o == 2'b10 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          r.hi = 0;
          r.lo = 32'h8000_0000;
        end else if (o == 2'b10) begin
          sa = $signed(a);
          sb = $signed(b);
          r.lo = sa / sb;
          r.hi = sa % sb;
        end else begin
          r.lo = a / b;
          r.hi = a % b;
        end
`endif
      end
    endcase
    return r;
  endfunction

  // Wait for the unit to leave busy, within a fixed cycle budget.
  task automatic waitIdle();
    int n = 0;
    while (busy && n < 200) begin
      @(posedge CLK); #1;
      n++;
    end
    if (busy) checkOutput("idle_timeout", 64'(busy), 64'(0));
  endtask

  // Issue one op once the unit is idle. Any MTHI/MTLO write given here lands
  // together with the start.
  task automatic applyStimulus(input logic [1:0] o, input logic [W-1:0] a,
                               input logic [W-1:0] b, input logic hwe,
                               input logic [W-1:0] hd, input logic lwe,
                               input logic [W-1:0] ld);
    exp_t e;
    waitIdle();
    start = 1'b1; op = o; rs_data = a; rt_data = b;
    hi_we = hwe; hi_wdata = hd; lo_we = lwe; lo_wdata = ld;
    if (hwe) mHi = hd;
    if (lwe) mLo = ld;
    e = refModel(o, a, b, mHi, mLo);
    expQ.push_back(e);
    mHi = e.hi;
    mLo = e.lo;
    @(posedge CLK); #1;
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    rs_data = $urandom; rt_data = $urandom;
  endtask

  // Monitor: on each falling edge, count busy cycles and check every done pulse.
  always @(negedge CLK) begin
    exp_t e;
    if (reset) begin
      busyRun = 0;
    end else begin
      if (busy) busyRun++;
      if (done) begin
        if (expQ.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_done actual=1 expected=0");
        end else begin
          e = expQ.pop_front();
          checkOutput("result_hi", 64'(hi), 64'(e.hi));
          checkOutput("result_lo", 64'(lo), 64'(e.lo));
          checkOutput("busy_cycles", 64'(busyRun), 64'(W + 1));
          checkOutput("busy_at_done", 64'(busy), 64'(0));
        end
        busyRun = 0;
      end
    end
  end

  // Main stimulus sequence.
  initial begin
    logic [1:0]   rop;
    logic [W-1:0] ra, rb;
    int           n;
    checks = 0; failures = 0; busyRun = 0;
    mHi = 0; mLo = 0;
    reset = 1'b1; start = 1'b0; op = 2'b00; rs_data = 0; rt_data = 0;
    hi_we = 1'b0; lo_we = 1'b0; hi_wdata = 0; lo_wdata = 0;
    repeat (3) @(posedge CLK);
    #1 reset = 1'b0;

    checkOutput("reset_busy", 64'(busy), 64'(0));
    checkOutput("reset_done", 64'(done), 64'(0));
    checkOutput("reset_hi", 64'(hi), 64'(0));
    checkOutput("reset_lo", 64'(lo), 64'(0));

    applyStimulus(2'b01, 32'hFFFF_FFFF, 32'h2, 0, 0, 0, 0);
    applyStimulus(2'b00, 32'hFFFF_FFFD, 32'h7, 0, 0, 0, 0);
    applyStimulus(2'b10, 32'hFFFF_FFF9, 32'h2, 0, 0, 0, 0);
    applyStimulus(2'b11, 32'h1234, 32'h0, 0, 0, 0, 0);
    applyStimulus(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, 0);

    // Start plus MTHI while busy must both be dropped.
    applyStimulus(2'b01, 32'd3, 32'd5, 0, 0, 0, 0);
    repeat (8) begin @(posedge CLK); #1; end
    start = 1'b1; op = 2'b00; rs_data = $urandom; rt_data = $urandom;
    hi_we = 1'b1; hi_wdata = 32'hAAAA;
    @(posedge CLK); #1;
    start = 1'b0; hi_we = 1'b0;
    checkOutput("busy_ignores_start", 64'(busy), 64'(1));

    // MTHI/MTLO in idle.
    waitIdle();
    hi_we = 1'b1; hi_wdata = 32'hDEAD;
    @(posedge CLK); #1;
    hi_we = 1'b0; mHi = 32'hDEAD;
    checkOutput("mthi", 64'(hi), 64'(mHi));
    lo_we = 1'b1; lo_wdata = 32'hBEEF;
    @(posedge CLK); #1;
    lo_we = 1'b0; mLo = 32'hBEEF;
    checkOutput("mtlo", 64'(lo), 64'(mLo));

    // Random ops. Each one starts in the previous op's done cycle, so every
    // op is issued back-to-back and its busy length is checked by the monitor.
    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      n   = $urandom_range(0, 7);
      if (n == 0) rb = 0;
      else if (n < 3) rb = 32'($urandom_range(1, 300));
      else if (n == 3) ra = 32'($urandom_range(0, 1000));
      applyStimulus(rop, ra, rb, ($urandom_range(0, 3) == 0), $urandom,
                    ($urandom_range(0, 3) == 0), $urandom);
    end

    // Reset in the middle of a DIVU. No result and no done pulse may follow.
    applyStimulus(2'b11, 32'h0009_8765, 32'h0000_0123, 0, 0, 0, 0);
    repeat (19) begin @(posedge CLK); #1; end
    reset = 1'b1;
    @(posedge CLK); #1;
    expQ.delete();
    mHi = 0; mLo = 0;
    checkOutput("midreset_busy", 64'(busy), 64'(0));
    checkOutput("midreset_done", 64'(done), 64'(0));
    checkOutput("midreset_hi", 64'(hi), 64'(0));
    checkOutput("midreset_lo", 64'(lo), 64'(0));
    reset = 1'b0;
    repeat (40) begin @(posedge CLK); #1; end

    // Multiply-only build: DIVU keeps HI/LO but still completes.
    applyStimulus(2'b11, 32'h0000_4321, 32'h0000_0007, 1, 32'h1111, 1, 32'h2222);

    n = 0;
    while (expQ.size() != 0 && n < 200) begin
      @(posedge CLK); #1;
      n++;
    end
    if (expQ.size() != 0) checkOutput("drain_timeout", 64'(expQ.size()), 64'(0));
    repeat (3) @(posedge CLK);
    #1;
    checkOutput("final_hi", 64'(hi), 64'(mHi));
    checkOutput("final_lo", 64'(lo), 64'(mLo));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard stop in case something wedges.
  initial begin
    #1000000;
    $display("[TB] FAIL global_timeout actual=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative multiply/divide unit with HI/LO result registers for the MIPS datapath. Sits directly downstream of the register file: it takes the two register read ports (rs on port 1, rt on port 2) as operands and executes MULT, MULTU, DIV and DIVU over multiple cycles. It holds the product or quotient/remainder in HI/LO for MFHI/MFLO. It stalls the pipeline through `busy` and reports completion through `done`.

## Interface
- `W`, default 32: operand and HI/LO width.
- `CLK` input 1: clock; all state changes on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `start` input 1: request an operation; sampled only in IDLE.
- `op` input 2: operation select.
  - 00 = MULT (signed).
  - 01 = MULTU.
  - 10 = DIV (signed).
  - 11 = DIVU.
- `rs_data` input W: multiplicand or dividend, taken from register file read port 1.
- `rt_data` input W: multiplier or divisor, taken from register file read port 2.
- `hi_we` input 1: MTHI write enable.
- `lo_we` input 1: MTLO write enable.
- `hi_wdata` input W: MTHI data.
- `lo_wdata` input W: MTLO data.
- `busy` output 1: operation in progress; the pipeline must stall MFHI/MFLO and new start requests.
- `done` output 1: one-cycle pulse; HI/LO hold the new result in this same cycle.
- `hi` output W: HI register (product upper half, or remainder).
- `lo` output W: LO register (product lower half, or quotient).

## Operation
- States and transitions:
  - IDLE → RUN on `start`.
  - RUN → FIX after W iterations.
  - FIX → IDLE.
- IDLE:
  - On `start`, latch `op`, `rs_data` and `rt_data`.
  - For signed ops, convert both operands to magnitudes and record the result signs.
  - Clear the iteration counter (width $clog2(W)+1) and go to RUN.
- RUN, one iteration per cycle, W cycles in total:
  - Multiply: shift-add into a 2W-bit accumulator.
  - Divide: restoring step on a 2W-bit remainder/quotient register.
- FIX:
  - Apply signs.
    - Product is negated when the operand signs differ.
    - Quotient is negated when the operand signs differ.
    - Remainder takes the sign of the dividend.
  - Write HI/LO, pulse `done`, return to IDLE.
- Multiply result: full 2W-bit product; HI = upper W bits, LO = lower W bits.
- Divide by zero (DIV or DIVU): LO = all ones, HI = `rs_data`. The unit still takes the full latency.
- Signed overflow, 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- `start` while `busy` is ignored; there is no queueing.
- `hi_we` / `lo_we` are honoured only when `busy` = 0. While busy they are dropped.
- If `hi_we` / `lo_we` coincide with an accepted `start`, the write takes effect on that edge and the later result overwrites it.
- HI and LO are never cleared except by reset or an op result.

## Timing
- Reset values:
  - State IDLE.
  - `busy` = 0.
  - `done` = 0.
  - `hi` = 0.
  - `lo` = 0.
  - Counter and internal operand registers = 0.
- `start` sampled at edge E0:
  - `busy` = 1 from after E0 through edge E(W+1), i.e. W+1 cycles.
  - `done` = 1 for exactly the one cycle after E(W+1), with `busy` = 0.
  - `hi` / `lo` update on E(W+1).
- Total latency from `start` edge to result visible: W+1 cycles. For W = 32, this is 33 cycles.
- Back-to-back: a `start` asserted in the `done` cycle is accepted; its own `done` arrives W+1 cycles later.
- Reset asserted mid-operation, at any cycle of RUN or FIX:
  - Next edge returns to IDLE.
  - `busy` = 0, `done` = 0.
  - HI/LO = 0.
  - No partial result is written.
- Operand inputs may change freely after E0; only the latched copies are used.

## Configuration
- Macro `MDU_DIV_EN`.
- Defined: DIV and DIVU are implemented as described above.
- Undefined:
  - Divider datapath is compiled out.
  - `start` with op[1] = 1 is accepted but performs no arithmetic; it takes the same W+1 latency.
  - `done` pulses and HI/LO are left unchanged.
  - Multiply behaviour and timing are identical in both builds.

## Test plan
- Basic multiply:
  - Reset, then MULTU with rs = 0xFFFFFFFF, rt = 0x00000002.
  - Required: `done` 33 cycles after start, HI = 0x00000001, LO = 0xFFFFFFFE, `busy` high for exactly 33 cycles.
- Signed multiply and divide:
  - MULT rs = 0xFFFFFFFD (−3), rt = 7 → HI = 0xFFFFFFFF, LO = 0xFFFFFFEB.
  - DIV rs = −7, rt = 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
- Divide corner cases:
  - DIVU rs = 0x1234, rt = 0 → LO = 0xFFFFFFFF, HI = 0x00001234.
  - DIV 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0.
- Busy protection:
  - Start MULTU 3×5, then in cycle 10 assert `start` with new operands plus `hi_we` with 0xAAAA.
  - Required: the second start and the write are ignored; HI = 0, LO = 15 at `done`.
- Back-to-back and MTHI/MTLO:
  - Assert `start` in the `done` cycle → second `done` exactly 33 cycles later.
  - In IDLE, `hi_we` with 0xDEAD → `hi` = 0xDEAD on the next cycle.
- Reset mid-operation:
  - Assert reset at cycle 20 of a DIVU.
  - Required: next cycle `busy` = 0, HI = LO = 0, and no `done` pulse follows.
  - With `MDU_DIV_EN` undefined, DIVU leaves HI/LO unchanged but still pulses `done` at 33 cycles.
